vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA timing and pixel-output engine. It generates hsync, vsync and data-enable from programmable horizontal and vertical porch and sync parameters, plus pixel coordinates and line/frame markers. It drives 8-bit RGB332 from a built-in test pattern or from an external pixel source. The block sits between the PLL pixel clock and the board pins, and the top level instantiates it in place of hand-coded counters.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 56 / 56 / 80, horizontal front porch, sync and back porch in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 1 / 3 / 25, vertical front porch, sync and back porch in lines
- HS_POL / VS_POL, 0 / 0, sync active level (0 = active-low)
- PIX_LAT, 1, cycles from x/y output to valid pix_in (0..7)
- CLK  in  1  pixel clock; all logic on its rising edge
- RST  in  1  asynchronous, active-high reset
- ce  in  1  pixel enable; all state advances only when ce=1
- mode  in  2  0 = black, 1 = colour bars, 2 = grid, 3 = external
- pix_in  in  8  external RGB332 pixel (R[7:5] G[4:2] B[1:0])
- x  out  HW  horizontal counter, HW = clog2(H_TOTAL)
- y  out  VW  vertical counter, VW = clog2(V_TOTAL)
- line_start  out  1  high while x==0
- frame_start  out  1  high while x==0 and y==0
- hsync, vsync, de  out  1  video timing, pipeline-aligned with rgb
- rgb  out  8  RGB332 pixel, 0 whenever de=0

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is formed the same way. Defaults give 832x509, VESA 640x480@85 at 36 MHz.
- x counts 0..H_TOTAL-1 and wraps to 0. y increments on each x wrap, counts 0..V_TOTAL-1, and wraps to 0 when x and y both wrap.
- Stage-0 decode:
  - active = x<H_ACTIVE && y<V_ACTIVE
  - hs_act = H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC
  - vs_act = V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC
  - vs_act is evaluated on the whole line, so vsync edges coincide with x==0.
- hsync = hs_act ? HS_POL : ~HS_POL. vsync follows the same rule with vs_act and VS_POL.
- mode is captured into mode_q only on the ce cycle where x wraps H_TOTAL-1→0 and y wraps V_TOTAL-1→0. A mid-frame change takes effect at the next frame, so there is no tearing.
- Pattern, in mode_q, for active pixels:
  - 0: 0x00
  - 1: eight vertical bars. A bar index b (0..7) advances every H_ACTIVE/8 pixels using a sub-counter, with no divider. b resets to 0 at x==0. Colour = {3{~b[2]},3{~b[1]},2{~b[0]}}, so bar 0 is white (0xFF) and bar 7 is black.
  - 2: 0xFF when x[4:0]==0, y[4:0]==0, x==H_ACTIVE-1 or y==V_ACTIVE-1; otherwise 0x00
  - 3: pix_in
- Parameter rules:
  - H_ACTIVE must be a multiple of 8.
  - Every porch and sync parameter must be ≥1.
  - Violations fail elaboration with an assertion.

## Timing
- x, y, line_start and frame_start are registered stage-0 outputs.
- pix_in is sampled PIX_LAT ce-cycles after the x,y it belongs to.
- hsync, vsync, de and rgb for coordinate (x,y) appear exactly PIX_LAT+1 ce-cycles after that x,y. Internal patterns are delayed through the same line, so latency is identical in every mode.
- Delay-line stages shift only when ce=1.
- ce=0 freezes every register: counters, delay line and outputs hold.
- Reset values (asynchronous):
  - x=0, y=0
  - line_start=1, frame_start=1 (decoded from 0,0)
  - hsync=~HS_POL, vsync=~VS_POL, de=0, rgb=0
  - all delay stages hold inactive sync, de=0, rgb=0
  - mode_q=0, bar state 0
- Reset mid-line: everything returns to the values above immediately. On release, the first ce cycle advances x to 1.
- Boundaries:
  - At x==H_TOTAL-1 and y==V_TOTAL-1, the next ce cycle gives x=0, y=0, frame_start=1.
  - At x==H_TOTAL-1 with y<V_TOTAL-1, only y increments.

## Structure
- Package vga_pkg holds:
  - the mode enum (MODE_BLACK, MODE_BARS, MODE_GRID, MODE_EXT)
  - the rgb332_t typedef
  - the default timing constants for 640x480@85
- One sub-module, vga_delay_line: a parametrised-width, parametrised-depth shift register with ce and a per-instance reset value. It is used for the {hsync, vsync, de, rgb} bundle and for pattern alignment.

## Test plan
- Defaults, mode 0, ce=1, one full frame → hsync low for 56 cycles per line starting at output x=696+PIX_LAT+1; vsync low on lines 481..483; de high for 640x480 pixels; rgb always 0x00.
- Mode 1 → de-aligned rgb is 0xFF for x 0..79, 0xFC for x 80..159, …, 0x00 for x 560..639; rgb 0x00 during blanking.
- Mode 3, pix_in driven as a function of x,y delayed PIX_LAT → rgb equals the expected pixel at every active position; repeat with PIX_LAT=0 and PIX_LAT=3.
- Mode changed 1→2 mid-frame → output stays bars until frame_start, then grid; no mixed frame.
- ce toggled 1/0 randomly → output sequence equals the ce=1 reference with stalled cycles removed; all outputs hold while ce=0.
- RST asserted at x=300, y=200 → outputs go to reset values asynchronously; after release, x counts 1,2,… and sync polarity is correct with HS_POL=1 and VS_POL=1.

Source files
------------

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared types and default timing for the VGA timing / pixel-output engine.
//   mode_e        : output source selection (black, colour bars, grid, external)
//   rgb332_t      : 8-bit pixel, R[7:5] G[4:2] B[1:0]
//   vga_bundle_t  : per-pixel bundle carried through the alignment delay line
//   VGA_*         : default timing for 640x480@85 (832x509 total, 36 MHz)
//   bar_colour()  : colour of vertical bar b (bar 0 white .. bar 7 black)
// -----------------------------------------------------------------------------
package vga_pkg;

   typedef enum logic [1:0] {
      MODE_BLACK = 2'd0,
      MODE_BARS  = 2'd1,
      MODE_GRID  = 2'd2,
      MODE_EXT   = 2'd3
   } mode_e;

   typedef logic [7:0] rgb332_t;

   // Sync levels are stored already polarity-applied; ext selects pix_i at
   // the end of the line so the external path sees the same latency.
   typedef struct packed {
      logic    hs;
      logic    vs;
      logic    de;
      logic    ext;
      rgb332_t pix;
   } vga_bundle_t;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 56;
   localparam int VGA_H_SYNC   = 56;
   localparam int VGA_H_BP     = 80;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 1;
   localparam int VGA_V_SYNC   = 3;
   localparam int VGA_V_BP     = 25;
   localparam int VGA_PIX_LAT  = 1;

   function automatic rgb332_t bar_colour(input logic [2:0] b);
      return {{3{~b[2]}}, {3{~b[1]}}, {2{~b[0]}}};
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// -----------------------------------------------------------------------------
// vga_delay_line
// Shift register of DEPTH stages (DEPTH >= 1), W bits wide, advancing only
// when ce_i is high. Every stage resets asynchronously to RST_VAL.
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset
//   ce_i   : shift enable
//   d_i    : data in
//   q_o    : data out, DEPTH ce-cycles after d_i
// -----------------------------------------------------------------------------
module vga_delay_line #(
   parameter int           W       = 8,
   parameter int           DEPTH   = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         ce_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] stage_q [DEPTH];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= RST_VAL;
         end
      end else if (ce_i) begin
         stage_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Programmable VGA timing generator with built-in test patterns.
//   clk_i          : pixel clock
//   rst_i          : asynchronous active-high reset
//   ce_i           : pixel enable; nothing advances while low
//   mode_i         : source select, sampled only at the frame wrap
//   pix_i          : external RGB332 pixel, PIX_LAT ce-cycles after its x/y
//   x_o, y_o       : stage-0 pixel coordinates
//   line_start_o   : x_o == 0
//   frame_start_o  : x_o == 0 and y_o == 0
//   hsync_o, vsync_o, de_o, rgb_o : video outputs, PIX_LAT+1 ce-cycles
//                    after the coordinate they belong to
// -----------------------------------------------------------------------------
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int   H_ACTIVE = VGA_H_ACTIVE,
   parameter int   H_FP     = VGA_H_FP,
   parameter int   H_SYNC   = VGA_H_SYNC,
   parameter int   H_BP     = VGA_H_BP,
   parameter int   V_ACTIVE = VGA_V_ACTIVE,
   parameter int   V_FP     = VGA_V_FP,
   parameter int   V_SYNC   = VGA_V_SYNC,
   parameter int   V_BP     = VGA_V_BP,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0,
   parameter int   PIX_LAT  = VGA_PIX_LAT,
   localparam int  H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int  V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int  HW       = $clog2(H_TOTAL),
   localparam int  VW       = $clog2(V_TOTAL)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          ce_i,
   input  logic [1:0]    mode_i,
   input  rgb332_t       pix_i,
   output logic [HW-1:0] x_o,
   output logic [VW-1:0] y_o,
   output logic          line_start_o,
   output logic          frame_start_o,
   output logic          hsync_o,
   output logic          vsync_o,
   output logic          de_o,
   output rgb332_t       rgb_o
);

   // Elaboration-time parameter checks
   if (H_ACTIVE % 8 != 0) begin : g_err_hact
      $error("vga_timing_gen: H_ACTIVE must be a multiple of 8");
   end
   if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_err_porch
      $error("vga_timing_gen: porch and sync widths must be >= 1");
   end
   if (PIX_LAT < 0 || PIX_LAT > 7) begin : g_err_lat
      $error("vga_timing_gen: PIX_LAT must be 0..7");
   end

   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
   localparam logic [HW-1:0] HS_BEG     = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
   localparam logic [VW-1:0] VS_BEG     = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);

   // Bar stepping uses a sub-counter instead of dividing x.
   localparam int            BAR_W    = H_ACTIVE / 8;
   localparam int            SW       = (BAR_W > 1) ? $clog2(BAR_W) : 1;
   localparam logic [SW-1:0] SUB_LAST = SW'(BAR_W - 1);

   localparam vga_bundle_t BUNDLE_RST = '{hs: ~HS_POL, vs: ~VS_POL, de: 1'b0,
                                          ext: 1'b0, pix: 8'h00};

   logic [HW-1:0] x_q, x_d;
   logic [VW-1:0] y_q, y_d;
   logic [SW-1:0] sub_q, sub_d;
   logic [2:0]    bar_q, bar_d;
   mode_e         mode_q, mode_d;
   logic          line_start_q, frame_start_q;
   logic          hsync_q, vsync_q, de_q;
   rgb332_t       rgb_q;
   vga_bundle_t   s0, dl;

   // ---------------- stage 0: counters ----------------
   always_comb begin
      x_d    = x_q;
      y_d    = y_q;
      sub_d  = sub_q;
      bar_d  = bar_q;
      mode_d = mode_q;
      if (x_q == H_LAST) begin
         x_d   = '0;
         sub_d = '0;
         bar_d = '0;
         if (y_q == V_LAST) begin
            y_d    = '0;
            // Mode only changes on the frame wrap, so a frame is never mixed.
            mode_d = mode_e'(mode_i);
         end else begin
            y_d = y_q + VW'(1);
         end
      end else begin
         x_d = x_q + HW'(1);
         if (sub_q == SUB_LAST) begin
            sub_d = '0;
            bar_d = bar_q + 3'd1;
         end else begin
            sub_d = sub_q + SW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         x_q           <= '0;
         y_q           <= '0;
         sub_q         <= '0;
         bar_q         <= '0;
         mode_q        <= MODE_BLACK;
         line_start_q  <= 1'b1;
         frame_start_q <= 1'b1;
      end else if (ce_i) begin
         x_q           <= x_d;
         y_q           <= y_d;
         sub_q         <= sub_d;
         bar_q         <= bar_d;
         mode_q        <= mode_d;
         line_start_q  <= (x_d == '0);
         frame_start_q <= (x_d == '0) && (y_d == '0);
      end
   end

   // ---------------- stage 0: decode and pattern ----------------
   always_comb begin
      s0     = BUNDLE_RST;
      s0.de  = (x_q < H_ACT) && (y_q < V_ACT);
      s0.hs  = ((x_q >= HS_BEG) && (x_q < HS_END)) ? HS_POL : ~HS_POL;
      s0.vs  = ((y_q >= VS_BEG) && (y_q < VS_END)) ? VS_POL : ~VS_POL;
      s0.ext = (mode_q == MODE_EXT);
      s0.pix = 8'h00;
      if (s0.de) begin
         case (mode_q)
            MODE_BARS: s0.pix = bar_colour(bar_q);
            MODE_GRID: begin
               if (x_q[4:0] == 5'd0 || y_q[4:0] == 5'd0 ||
                   x_q == H_ACT_LAST || y_q == V_ACT_LAST) begin
                  s0.pix = 8'hFF;
               end
            end
            default:   s0.pix = 8'h00;
         endcase
      end
   end

   // ---------------- alignment with the external pixel source ----------------
   if (PIX_LAT == 0) begin : g_no_lat
      assign dl = s0;
   end else begin : g_lat
      vga_delay_line #(
         .W       ($bits(vga_bundle_t)),
         .DEPTH   (PIX_LAT),
         .RST_VAL (BUNDLE_RST)
      ) u_align (
         .clk_i (clk_i),
         .rst_i (rst_i),
         .ce_i  (ce_i),
         .d_i   (s0),
         .q_o   (dl)
      );
   end

   // ---------------- output register ----------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hsync_q <= ~HS_POL;
         vsync_q <= ~VS_POL;
         de_q    <= 1'b0;
         rgb_q   <= 8'h00;
      end else if (ce_i) begin
         hsync_q <= dl.hs;
         vsync_q <= dl.vs;
         de_q    <= dl.de;
         rgb_q   <= dl.de ? (dl.ext ? pix_i : dl.pix) : 8'h00;
      end
   end

   assign x_o           = x_q;
   assign y_o           = y_q;
   assign line_start_o  = line_start_q;
   assign frame_start_o = frame_start_q;
   assign hsync_o       = hsync_q;
   assign vsync_o       = vsync_q;
   assign de_o          = de_q;
   assign rgb_o         = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Three instances with a reduced 80x48 raster run side by side:
//   u0: PIX_LAT=1, active-low syncs
//   u1: PIX_LAT=0, active-high syncs
//   u2: PIX_LAT=3, active-low syncs
// The reference derives every expected output from the ce-step count since
// reset: coordinate k = (k mod H_TOTAL, (k div H_TOTAL) mod V_TOTAL), the mode
// of the frame containing k, and the raster rules.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;
   import vga_pkg::*;

   localparam int HA  = 64;
   localparam int HF  = 4;
   localparam int HSY = 6;
   localparam int HB  = 6;
   localparam int VA  = 40;
   localparam int VF  = 1;
   localparam int VSY = 3;
   localparam int VB  = 4;
   localparam int HT  = HA + HF + HSY + HB;
   localparam int VT  = VA + VF + VSY + VB;
   localparam int FS  = HT * VT;
   localparam int HW  = $clog2(HT);
   localparam int VW  = $clog2(VT);
   localparam int NI  = 3;

   logic          clk  = 1'b0;
   logic          rst  = 1'b1;
   logic          ce   = 1'b0;
   logic [1:0]    mode = 2'd0;
   logic [7:0]    pix_w [NI];
   logic [HW-1:0] x_w   [NI];
   logic [VW-1:0] y_w   [NI];
   logic          ls_w  [NI];
   logic          fs_w  [NI];
   logic          hs_w  [NI];
   logic          vs_w  [NI];
   logic          de_w  [NI];
   logic [7:0]    rgb_w [NI];

   int n_checks = 0;
   int n_fail   = 0;
   int n        = 0;     // ce steps since reset release
   int frame_mode [$];   // mode in force for each frame since reset

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      vga_timing_gen #(
         .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HSY), .H_BP (HB),
         .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VSY), .V_BP (VB),
         .HS_POL   (gi == 1), .VS_POL (gi == 1),
         .PIX_LAT  ((gi == 0) ? 1 : ((gi == 1) ? 0 : 3))
      ) u_dut (
         .clk_i         (clk),
         .rst_i         (rst),
         .ce_i          (ce),
         .mode_i        (mode),
         .pix_i         (pix_w[gi]),
         .x_o           (x_w[gi]),
         .y_o           (y_w[gi]),
         .line_start_o  (ls_w[gi]),
         .frame_start_o (fs_w[gi]),
         .hsync_o       (hs_w[gi]),
         .vsync_o       (vs_w[gi]),
         .de_o          (de_w[gi]),
         .rgb_o         (rgb_w[gi])
      );
   end

   function automatic int lat_of(input int i);
      return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
   endfunction

   function automatic logic pol_of(input int i);
      return (i == 1);
   endfunction

   function automatic logic [7:0] ext_pix(input int x, input int y);
      return 8'((x * 7 + y * 29) ^ 32'h5A);
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h (step %0d, t=%0t)",
                  tag, act, exp, n, $time);
      end
   endtask

   // Expected video outputs of instance i after `step` ce cycles.
   task automatic expect_out(input int i, input int step,
                             output logic e_hs, output logic e_vs,
                             output logic e_de, output logic [7:0] e_rgb);
      int k, x, y, m, b;
      logic [2:0] r, g;
      logic [1:0] bl;
      k     = step - lat_of(i) - 1;
      e_hs  = ~pol_of(i);
      e_vs  = ~pol_of(i);
      e_de  = 1'b0;
      e_rgb = 8'h00;
      if (k >= 0) begin
         x    = k % HT;
         y    = (k / HT) % VT;
         e_de = (x < HA) && (y < VA);
         if (x >= HA + HF && x < HA + HF + HSY) e_hs = pol_of(i);
         if (y >= VA + VF && y < VA + VF + VSY) e_vs = pol_of(i);
         m = frame_mode[k / FS];
         if (e_de) begin
            case (m)
               1: begin
                  b     = x / (HA / 8);
                  r     = (b < 4)       ? 3'd7 : 3'd0;
                  g     = ((b % 4) < 2) ? 3'd7 : 3'd0;
                  bl    = (b % 2 == 0)  ? 2'd3 : 2'd0;
                  e_rgb = {r, g, bl};
               end
               2: if (x % 32 == 0 || y % 32 == 0 || x == HA - 1 || y == VA - 1) e_rgb = 8'hFF;
               3: e_rgb = ext_pix(x, y);
               default: e_rgb = 8'h00;
            endcase
         end
      end
   endtask

   // External source presents the pixel of coordinate n-PIX_LAT during step n.
   task automatic drive_pix();
      int k;
      for (int i = 0; i < NI; i++) begin
         k = n - lat_of(i);
         pix_w[i] = (k >= 0) ? ext_pix(k % HT, (k / HT) % VT) : 8'h00;
      end
   endtask

   task automatic check_all();
      logic e_hs, e_vs, e_de;
      logic [7:0] e_rgb;
      int ex, ey;
      ex = n % HT;
      ey = (n / HT) % VT;
      for (int i = 0; i < NI; i++) begin
         expect_out(i, n, e_hs, e_vs, e_de, e_rgb);
         check_eq($sformatf("u%0d.x", i),     32'(x_w[i]),  32'(ex));
         check_eq($sformatf("u%0d.y", i),     32'(y_w[i]),  32'(ey));
         check_eq($sformatf("u%0d.ls", i),    32'(ls_w[i]), 32'(ex == 0));
         check_eq($sformatf("u%0d.fs", i),    32'(fs_w[i]), 32'(ex == 0 && ey == 0));
         check_eq($sformatf("u%0d.hsync", i), 32'(hs_w[i]), 32'(e_hs));
         check_eq($sformatf("u%0d.vsync", i), 32'(vs_w[i]), 32'(e_vs));
         check_eq($sformatf("u%0d.de", i),    32'(de_w[i]), 32'(e_de));
         check_eq($sformatf("u%0d.rgb", i),   32'(rgb_w[i]), 32'(e_rgb));
      end
   endtask

   // Called at posedge+1; applies ce for the next edge and checks after it.
   task automatic tick(input logic ce_v);
      ce = ce_v;
      @(posedge clk);
      if (ce_v && !rst) begin
         n++;
         if (n % FS == 0) begin
            frame_mode.push_back(int'(mode));
            $display("frame %0d begins with mode %0d at step %0d", n / FS, mode, n);
         end
      end
      #1;
      drive_pix();
      check_all();
   endtask

   task automatic run_until(input int target, input bit rand_ce);
      int guard;
      guard = 0;
      while (n < target && guard < 4 * target + 100) begin
         tick(rand_ce ? logic'($urandom_range(0, 2) != 0) : 1'b1);
         guard++;
      end
      check_eq("run_bound", 32'(n >= target), 32'd1);
   endtask

   task automatic model_reset();
      n = 0;
      frame_mode.delete();
      frame_mode.push_back(0);
      drive_pix();
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();                 // reset state
      rst = 1'b0;
      tick(1'b0);                  // ce low: nothing moves
      tick(1'b0);

      mode = 2'd1;                 // frame 0 must stay black regardless
      run_until(FS + FS / 2, 1'b0);
      $display("mode change 1->2 mid-frame at step %0d", n);
      mode = 2'd2;
      run_until(2 * FS + FS / 2, 1'b0);
      mode = 2'd3;
      run_until(4 * FS + 20 * HT + 30, 1'b1);

      // Asynchronous reset in the middle of a line at x=30, y=20.
      $display("async reset at x=%0d y=%0d", x_w[0], y_w[0]);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all();
      tick(1'b1);                  // clock edges during reset change nothing
      tick(1'b1);
      rst = 1'b0;
      run_until(FS + FS / 2, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
